pong_ball_engine: RTL and testbench
===================================

Name: pong_ball_engine

Overview:
- Parametrised ball-physics engine for the VGA pong game.
- Owns ball position, direction and speed.
- Handles up to N_PADDLES paddles facing either side, optional re-serve after a miss, and speed-up on paddle hit with saturation.
- Emits one-cycle event pulses (paddle hit, wall miss) for the scoring logic; the pixel renderer reads ball_x/ball_y.

Parameters:
- H_RES, 640, screen width in pixels
- V_RES, 480, screen height in pixels
- BALL_SIZE, 20, ball side length in pixels
- N_PADDLES, 2, number of paddle channels
- PADDLE_W, 15, paddle width
- PADDLE_H, 180, paddle height
- PERIOD, 2500000, accumulator threshold for one pixel step
- VEL_W, 16, velocity register width
- V_INIT_H, 12, serve horizontal velocity
- V_INIT_V, 16, serve vertical velocity
- V_STEP_H, 4, horizontal increment per hit
- V_STEP_V, 3, vertical increment per hit
- V_MAX, 64, velocity saturation value (both axes)
- SERVE_X, 50, serve x
- SERVE_Y, 240, serve y
- MISS_RESERVE, 0, 0 = bounce off side walls, 1 = re-serve after side-wall miss
- SERVE_DELAY, 0, run-enabled cycles spent in SERVE before PLAY

Ports:
- CLOCK_50  in  1  single clock
- reset  in  1  synchronous, active-high
- run  in  1  motion enable (pause when 0)
- restart  in  1  synchronous soft restart, level-sampled
- paddle_x  in  10*N_PADDLES  left edge of paddle i at bits [10i+9:10i]
- paddle_y  in  10*N_PADDLES  top edge of paddle i
- paddle_side  in  N_PADDLES  1 = face toward left (ball moving right hits it), 0 = face toward right
- ball_x  out  10  ball left edge
- ball_y  out  10  ball top edge
- dir_h  out  1  1 = right, 0 = left
- dir_v  out  1  1 = up, 0 = down
- vel_h  out  VEL_W  current horizontal velocity
- vel_v  out  VEL_W  current vertical velocity
- hit  out  N_PADDLES  one-cycle pulse per paddle struck
- miss_left  out  1  one-cycle pulse, ball reached x=0 moving left
- miss_right  out  1  one-cycle pulse, ball reached x+BALL_SIZE=H_RES moving right
- serving  out  1  high while in SERVE

Behaviour:
- Reset values (also applied by restart, which ranks below reset and above all else):
  - ball_x=SERVE_X, ball_y=SERVE_Y, dir_h=1, dir_v=1
  - vel_h=V_INIT_H, vel_v=V_INIT_V
  - hit=0, miss_*=0, serving=1
  - accumulators=0, serve counter=0, state=SERVE
- States:
  - SERVE: ball held at serve point.
    - Serve counter increments on each run=1 cycle.
    - When counter==SERVE_DELAY, go to PLAY and clear counter; with SERVE_DELAY=0 this happens on the first run=1 cycle.
  - PLAY: motion as below. run=0 freezes accumulators, position and state.
- Per-axis accumulator (32 bit), evaluated on each run=1 edge in PLAY:
  - If acc>=PERIOD: take one step and set acc<=0.
  - Else: acc<=acc+vel.
  - A step therefore occurs every ceil(PERIOD/vel)+1 cycles.
- Horizontal step, in priority order:
  1. Paddle contact. Paddle i is hit when ball centre (ball_y+BALL_SIZE/2) lies strictly between paddle_y and paddle_y+PADDLE_H, and either:
     - dir_h=1, paddle_side=1 and ball_x+BALL_SIZE==paddle_x, or
     - dir_h=0, paddle_side=0 and ball_x==paddle_x+PADDLE_W.
     On contact: pulse hit[i] for every matching paddle, invert dir_h once, apply vel_h+=V_STEP_H and vel_v+=V_STEP_V once each (saturating at V_MAX), no position change.
  2. In-bounds move: x±1.
  3. Wall. Pulse miss_left or miss_right.
     - MISS_RESERVE=0: invert dir_h, no move.
     - MISS_RESERVE=1: enter SERVE with serve position and initial velocities; dir_h=1 after a left miss, dir_h=0 after a right miss; dir_v unchanged.
- Vertical step:
  - dir_v=1 and ball_y==0: set dir_v=0, no move.
  - dir_v=0 and ball_y+BALL_SIZE==V_RES: set dir_v=1, no move.
  - Otherwise y∓1.
- Simultaneous H and V steps in the same cycle both apply.
- A re-serve triggered by a miss overrides the vertical position update in that cycle.
- hit and miss pulses are registered, asserted exactly one cycle, zero otherwise.
- Arithmetic: position compares are done at 11 bits to avoid wrap.
- Velocity saturation: a hit with vel_h=V_MAX-2 yields V_MAX, not V_MAX+2.

Test Plan:
- Reset, then run=1, PERIOD=100, SERVE_DELAY=0 -> serving drops after 1 cycle; first x step to 51 occurs 10 cycles later (12*9=108, step on 10th edge).
- Ball at x=605, dir_h=1, paddle0 x=625 y=200 side=1, ball_y=240 -> next H step: hit[0] pulse, dir_h=0, vel_h=16, vel_v=19, ball_x stays 605.
- MISS_RESERVE=1, ball_x=620 moving right, no paddle overlap -> miss_right pulse; ball at (50,240), serving=1, dir_h=0, vel_h=12.
- ball_y=0, dir_v=1 -> dir_v=0 with y held at 0; next step y=1. ball_y=460, dir_v=0 -> dir_v=1.
- run=0 mid-PLAY for 50 cycles -> position and accumulators unchanged; restart asserted -> next cycle all reset values.
- Two paddles, both contacting on the same step -> hit=2'b11, single dir_h flip, vel_h incremented once; vel_h=62 before hit -> 64.

Source files
------------

// File: rtl/pong_ball_engine.sv
// Ball physics for the VGA pong game: position, direction and speed of the ball,
// paddle contact, wall handling and one-cycle hit/miss event pulses.
module pong_ball_engine #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 20,
    parameter int N_PADDLES    = 2,
    parameter int PADDLE_W     = 15,
    parameter int PADDLE_H     = 180,
    parameter int PERIOD       = 2500000,
    parameter int VEL_W        = 16,
    parameter int V_INIT_H     = 12,
    parameter int V_INIT_V     = 16,
    parameter int V_STEP_H     = 4,
    parameter int V_STEP_V     = 3,
    parameter int V_MAX        = 64,
    parameter int SERVE_X      = 50,
    parameter int SERVE_Y      = 240,
    parameter int MISS_RESERVE = 0,
    parameter int SERVE_DELAY  = 0
) (
    input  logic                     CLOCK_50,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     restart,
    input  logic [10*N_PADDLES-1:0]  paddle_x,
    input  logic [10*N_PADDLES-1:0]  paddle_y,
    input  logic [N_PADDLES-1:0]     paddle_side,
    output logic [9:0]               ball_x,
    output logic [9:0]               ball_y,
    output logic                     dir_h,
    output logic                     dir_v,
    output logic [VEL_W-1:0]         vel_h,
    output logic [VEL_W-1:0]         vel_v,
    output logic [N_PADDLES-1:0]     hit,
    output logic                     miss_left,
    output logic                     miss_right,
    output logic                     serving
);
    // state   | meaning
    // S_SERVE | ball parked at serve point, counting run cycles up to SERVE_DELAY
    // S_PLAY  | ball moving; each axis steps when its accumulator reaches PERIOD
    typedef enum logic [0:0] {S_SERVE = 1'b0, S_PLAY = 1'b1} state_t;

    localparam int CNT_W = (SERVE_DELAY > 0) ? $clog2(SERVE_DELAY + 1) : 1;
    localparam logic [CNT_W-1:0] SERVE_END  = CNT_W'(SERVE_DELAY);
    localparam logic [31:0]      PERIOD_U   = 32'(PERIOD);
    localparam logic [10:0]      BS11       = 11'(BALL_SIZE);
    localparam logic [10:0]      HALF11     = 11'(BALL_SIZE / 2);
    localparam logic [10:0]      H_RES11    = 11'(H_RES);
    localparam logic [10:0]      V_RES11    = 11'(V_RES);
    localparam logic [10:0]      PAD_W11    = 11'(PADDLE_W);
    localparam logic [10:0]      PAD_H11    = 11'(PADDLE_H);
    localparam logic [9:0]       SERVE_X10  = 10'(SERVE_X);
    localparam logic [9:0]       SERVE_Y10  = 10'(SERVE_Y);
    localparam logic [VEL_W-1:0] VIH        = VEL_W'(V_INIT_H);
    localparam logic [VEL_W-1:0] VIV        = VEL_W'(V_INIT_V);
    localparam logic [VEL_W-1:0] VSH        = VEL_W'(V_STEP_H);
    localparam logic [VEL_W-1:0] VSV        = VEL_W'(V_STEP_V);
    localparam logic [VEL_W:0]   V_MAX_X    = (VEL_W + 1)'(V_MAX);

    state_t                 state_q, state_d;
    logic [9:0]             ball_x_q, ball_x_d, ball_y_q, ball_y_d;
    logic                   dir_h_q, dir_h_d, dir_v_q, dir_v_d;
    logic [VEL_W-1:0]       vel_h_q, vel_h_d, vel_v_q, vel_v_d;
    logic [31:0]            acc_h_q, acc_h_d, acc_v_q, acc_v_d;
    logic [CNT_W-1:0]       serve_cnt_q, serve_cnt_d;
    logic [N_PADDLES-1:0]   hit_q, hit_d;
    logic                   miss_left_q, miss_left_d, miss_right_q, miss_right_d;

    logic [10:0]            bx11, by11, cy11;
    logic [N_PADDLES-1:0]   contact;
    logic                   h_step, v_step, reserve;

    function automatic logic [VEL_W-1:0] sat_add(input logic [VEL_W-1:0] v,
                                                 input logic [VEL_W-1:0] inc);
        logic [VEL_W:0] sum;
        sum = {1'b0, v} + {1'b0, inc};
        return (sum > V_MAX_X) ? V_MAX_X[VEL_W-1:0] : sum[VEL_W-1:0];
    endfunction

    // Compares are 11 bits wide so paddle_y + PADDLE_H and edge sums cannot wrap.
    assign bx11 = {1'b0, ball_x_q};
    assign by11 = {1'b0, ball_y_q};
    assign cy11 = by11 + HALF11;

    for (genvar g = 0; g < N_PADDLES; g++) begin : g_pad
        logic [10:0] px11, py11;
        logic        in_band, face_hit;
        assign px11     = {1'b0, paddle_x[10*g +: 10]};
        assign py11     = {1'b0, paddle_y[10*g +: 10]};
        assign in_band  = (cy11 > py11) && (cy11 < py11 + PAD_H11);
        assign face_hit = (dir_h_q && paddle_side[g] && (bx11 + BS11 == px11)) ||
                          (!dir_h_q && !paddle_side[g] && (bx11 == px11 + PAD_W11));
        assign contact[g] = in_band && face_hit;
    end

    always_comb begin
        state_d      = state_q;
        ball_x_d     = ball_x_q;
        ball_y_d     = ball_y_q;
        dir_h_d      = dir_h_q;
        dir_v_d      = dir_v_q;
        vel_h_d      = vel_h_q;
        vel_v_d      = vel_v_q;
        acc_h_d      = acc_h_q;
        acc_v_d      = acc_v_q;
        serve_cnt_d  = serve_cnt_q;
        hit_d        = '0;
        miss_left_d  = 1'b0;
        miss_right_d = 1'b0;
        h_step       = 1'b0;
        v_step       = 1'b0;
        reserve      = 1'b0;

        if (run) begin
            case (state_q)
                S_SERVE: begin
                    if (serve_cnt_q == SERVE_END) begin
                        state_d     = S_PLAY;
                        serve_cnt_d = '0;
                    end else begin
                        serve_cnt_d = serve_cnt_q + CNT_W'(1);
                    end
                end
                S_PLAY: begin
                    h_step  = (acc_h_q >= PERIOD_U);
                    v_step  = (acc_v_q >= PERIOD_U);
                    acc_h_d = h_step ? 32'd0 : acc_h_q + 32'(vel_h_q);
                    acc_v_d = v_step ? 32'd0 : acc_v_q + 32'(vel_v_q);

                    if (h_step) begin
                        if (|contact) begin
                            hit_d   = contact;
                            dir_h_d = ~dir_h_q;
                            vel_h_d = sat_add(vel_h_q, VSH);
                            vel_v_d = sat_add(vel_v_q, VSV);
                        end else if (dir_h_q) begin
                            if (bx11 + BS11 < H_RES11) begin
                                ball_x_d = ball_x_q + 10'd1;
                            end else begin
                                miss_right_d = 1'b1;
                                reserve      = (MISS_RESERVE != 0);
                                dir_h_d      = 1'b0;
                            end
                        end else begin
                            if (ball_x_q != 10'd0) begin
                                ball_x_d = ball_x_q - 10'd1;
                            end else begin
                                miss_left_d = 1'b1;
                                reserve     = (MISS_RESERVE != 0);
                                dir_h_d     = 1'b1;
                            end
                        end
                    end

                    if (v_step) begin
                        if (dir_v_q && ball_y_q == 10'd0) begin
                            dir_v_d = 1'b0;
                        end else if (!dir_v_q && by11 + BS11 == V_RES11) begin
                            dir_v_d = 1'b1;
                        end else begin
                            ball_y_d = dir_v_q ? ball_y_q - 10'd1 : ball_y_q + 10'd1;
                        end
                    end

                    // A re-serve wins over this cycle's vertical update.
                    if (reserve) begin
                        state_d  = S_SERVE;
                        ball_x_d = SERVE_X10;
                        ball_y_d = SERVE_Y10;
                        vel_h_d  = VIH;
                        vel_v_d  = VIV;
                        dir_v_d  = dir_v_q;
                    end
                end
                default: state_d = S_SERVE;
            endcase
        end

        if (restart) begin
            state_d      = S_SERVE;
            ball_x_d     = SERVE_X10;
            ball_y_d     = SERVE_Y10;
            dir_h_d      = 1'b1;
            dir_v_d      = 1'b1;
            vel_h_d      = VIH;
            vel_v_d      = VIV;
            acc_h_d      = 32'd0;
            acc_v_d      = 32'd0;
            serve_cnt_d  = '0;
            hit_d        = '0;
            miss_left_d  = 1'b0;
            miss_right_d = 1'b0;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q      <= S_SERVE;
            ball_x_q     <= SERVE_X10;
            ball_y_q     <= SERVE_Y10;
            dir_h_q      <= 1'b1;
            dir_v_q      <= 1'b1;
            vel_h_q      <= VIH;
            vel_v_q      <= VIV;
            acc_h_q      <= 32'd0;
            acc_v_q      <= 32'd0;
            serve_cnt_q  <= '0;
            hit_q        <= '0;
            miss_left_q  <= 1'b0;
            miss_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ball_x_q     <= ball_x_d;
            ball_y_q     <= ball_y_d;
            dir_h_q      <= dir_h_d;
            dir_v_q      <= dir_v_d;
            vel_h_q      <= vel_h_d;
            vel_v_q      <= vel_v_d;
            acc_h_q      <= acc_h_d;
            acc_v_q      <= acc_v_d;
            serve_cnt_q  <= serve_cnt_d;
            hit_q        <= hit_d;
            miss_left_q  <= miss_left_d;
            miss_right_q <= miss_right_d;
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign dir_h      = dir_h_q;
    assign dir_v      = dir_v_q;
    assign vel_h      = vel_h_q;
    assign vel_v      = vel_v_q;
    assign hit        = hit_q;
    assign miss_left  = miss_left_q;
    assign miss_right = miss_right_q;
    assign serving    = (state_q == S_SERVE);

endmodule

// File: tb/tb_pong_ball_engine.sv
// Bench for pong_ball_engine: two instances (bounce-off-wall and re-serve variants)
// checked every cycle against a behavioural model, plus directed scenario checks.
module tb_pong_ball_engine;
    localparam int PER  = 100;
    localparam int VMAX = 64;

    typedef struct {
        bit       play;
        int       cnt;
        int       x;
        int       y;
        bit       dh;
        bit       dv;
        int       vh;
        int       vv;
        int       acch;
        int       accv;
        bit [1:0] hit;
        bit       ml;
        bit       mr;
    } mdl_t;

    logic        clk;
    logic        reset;
    logic        run_a, run_b, restart_a, restart_b;
    logic [19:0] px_a, py_a, px_b, py_b;
    logic [1:0]  side_a, side_b;

    logic [9:0]  ball_x_a, ball_y_a, ball_x_b, ball_y_b;
    logic        dir_h_a, dir_v_a, dir_h_b, dir_v_b;
    logic [15:0] vel_h_a, vel_v_a, vel_h_b, vel_v_b;
    logic [1:0]  hit_a, hit_b;
    logic        miss_left_a, miss_right_a, serving_a;
    logic        miss_left_b, miss_right_b, serving_b;
    logic [58:0] obs_a, obs_b;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [58:0] exp_q[$];
    mdl_t        ma, mb, ma_n, mb_n;

    pong_ball_engine #(.PERIOD(PER)) u_a (
        .CLOCK_50(clk), .reset(reset), .run(run_a), .restart(restart_a),
        .paddle_x(px_a), .paddle_y(py_a), .paddle_side(side_a),
        .ball_x(ball_x_a), .ball_y(ball_y_a), .dir_h(dir_h_a), .dir_v(dir_v_a),
        .vel_h(vel_h_a), .vel_v(vel_v_a), .hit(hit_a),
        .miss_left(miss_left_a), .miss_right(miss_right_a), .serving(serving_a)
    );

    pong_ball_engine #(.PERIOD(PER), .MISS_RESERVE(1), .SERVE_DELAY(3), .V_INIT_H(58)) u_b (
        .CLOCK_50(clk), .reset(reset), .run(run_b), .restart(restart_b),
        .paddle_x(px_b), .paddle_y(py_b), .paddle_side(side_b),
        .ball_x(ball_x_b), .ball_y(ball_y_b), .dir_h(dir_h_b), .dir_v(dir_v_b),
        .vel_h(vel_h_b), .vel_v(vel_v_b), .hit(hit_b),
        .miss_left(miss_left_b), .miss_right(miss_right_b), .serving(serving_b)
    );

    assign obs_a = {ball_x_a, ball_y_a, dir_h_a, dir_v_a, vel_h_a, vel_v_a,
                    hit_a, miss_left_a, miss_right_a, serving_a};
    assign obs_b = {ball_x_b, ball_y_b, dir_h_b, dir_v_b, vel_h_b, vel_v_b,
                    hit_b, miss_left_b, miss_right_b, serving_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic mdl_t mdl_reset(int vih, int viv);
        mdl_t m;
        m.play = 0; m.cnt = 0; m.x = 50; m.y = 240; m.dh = 1; m.dv = 1;
        m.vh = vih; m.vv = viv; m.acch = 0; m.accv = 0;
        m.hit = 2'b00; m.ml = 0; m.mr = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(mdl_t s, bit rst, bit run, bit rs,
                                      logic [19:0] px, logic [19:0] py, logic [1:0] side,
                                      bit reserve_mode, int sdelay,
                                      int vih, int viv, int vsh, int vsv);
        mdl_t n;
        bit   hs, vs, resv, ndh;
        int   c, pxi, pyi;
        n = s;
        n.hit = 2'b00; n.ml = 0; n.mr = 0;
        resv = 0; ndh = 0;
        if (rst || rs) return mdl_reset(vih, viv);
        if (!run) return n;
        if (!s.play) begin
            if (s.cnt == sdelay) begin n.play = 1; n.cnt = 0; end
            else n.cnt = s.cnt + 1;
            return n;
        end
        hs = (s.acch >= PER);
        vs = (s.accv >= PER);
        n.acch = hs ? 0 : s.acch + s.vh;
        n.accv = vs ? 0 : s.accv + s.vv;
        if (hs) begin
            c = s.y + 10;
            for (int i = 0; i < 2; i++) begin
                pxi = int'(px[10*i +: 10]);
                pyi = int'(py[10*i +: 10]);
                if (c > pyi && c < pyi + 180 &&
                    ((s.dh && side[i] && s.x + 20 == pxi) ||
                     (!s.dh && !side[i] && s.x == pxi + 15)))
                    n.hit[i] = 1'b1;
            end
            if (n.hit != 2'b00) begin
                n.dh = !s.dh;
                n.vh = (s.vh + vsh > VMAX) ? VMAX : s.vh + vsh;
                n.vv = (s.vv + vsv > VMAX) ? VMAX : s.vv + vsv;
            end else if (s.dh) begin
                if (s.x + 20 < 640) n.x = s.x + 1;
                else begin n.mr = 1; resv = reserve_mode; ndh = 0; n.dh = 0; end
            end else begin
                if (s.x > 0) n.x = s.x - 1;
                else begin n.ml = 1; resv = reserve_mode; ndh = 1; n.dh = 1; end
            end
        end
        if (vs) begin
            if (s.dv && s.y == 0) n.dv = 0;
            else if (!s.dv && s.y + 20 == 480) n.dv = 1;
            else n.y = s.dv ? s.y - 1 : s.y + 1;
        end
        if (resv) begin
            n.play = 0; n.cnt = 0; n.x = 50; n.y = 240;
            n.vh = vih; n.vv = viv; n.dh = ndh; n.dv = s.dv;
        end
        return n;
    endfunction

    function automatic logic [58:0] mpack(mdl_t m);
        return {10'(m.x), 10'(m.y), m.dh, m.dv, 16'(m.vh), 16'(m.vv),
                m.hit, m.ml, m.mr, ~m.play};
    endfunction

    function automatic logic [9:0] pyc(int y);
        return (y >= 40) ? 10'(y - 40) : 10'd0;
    endfunction

    function automatic bit evt(mdl_t m, int kind);
        case (kind)
            0:       return m.hit != 2'b00;
            1:       return m.mr;
            default: return m.ml;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [58:0] obs, input logic [58:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bounce(input string tag, input mdl_t p, input mdl_t n,
                              input logic [9:0] oy, input logic odv, input logic rs);
        if (!rs && p.dv && !n.dv) chk({tag, "_top_bounce"}, 59'({oy, odv}), 59'({10'd0, 1'b0}));
        if (!rs && !p.dv && n.dv) chk({tag, "_bot_bounce"}, 59'({oy, odv}), 59'({10'd460, 1'b1}));
    endtask

    task automatic tick();
        logic [58:0] e;
        ma_n = mdl_next(ma, reset, run_a, restart_a, px_a, py_a, side_a, 0, 0, 12, 16, 4, 3);
        mb_n = mdl_next(mb, reset, run_b, restart_b, px_b, py_b, side_b, 1, 3, 58, 16, 4, 3);
        exp_q.push_back(mpack(ma_n));
        exp_q.push_back(mpack(mb_n));
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("a_cycle", obs_a, e);
        e = exp_q.pop_front();
        chk("b_cycle", obs_b, e);
        chk_bounce("a", ma, ma_n, ball_y_a, dir_v_a, reset || restart_a);
        chk_bounce("b", mb, mb_n, ball_y_b, dir_v_b, reset || restart_b);
        ma = ma_n;
        mb = mb_n;
        py_a = {pyc(ma.y), pyc(ma.y)};
        py_b = {pyc(mb.y), pyc(mb.y)};
    endtask

    task automatic run_until(input bit use_b, input int kind, input int budget, input string tag);
        bit seen;
        seen = 0;
        for (int k = 0; k < budget && !seen; k++) begin
            tick();
            seen = evt(use_b ? mb : ma, kind);
        end
        n_checks++;
        assert (seen) else begin
            n_errors++;
            $error("FAIL %s observed=no_event expected=event_within_%0d_cycles", tag, budget);
        end
    endtask

    initial begin
        reset = 1; run_a = 0; run_b = 0; restart_a = 0; restart_b = 0;
        px_a = {10'd0, 10'd625};   side_a = 2'b01; py_a = {10'd200, 10'd200};
        px_b = {10'd625, 10'd625}; side_b = 2'b11; py_b = {10'd200, 10'd200};
        ma = mdl_reset(12, 16);
        mb = mdl_reset(58, 16);
        repeat (3) tick();
        chk("rst_a_x", 59'(ball_x_a), 59'(50));
        chk("rst_a_y", 59'(ball_y_a), 59'(240));
        chk("rst_a_dirs", 59'({dir_h_a, dir_v_a, serving_a}), 59'(3'b111));
        chk("rst_a_vel", 59'({vel_h_a, vel_v_a}), 59'({16'd12, 16'd16}));
        chk("rst_b_vel_h", 59'(vel_h_b), 59'(58));

        // instance A: serve timing and first step
        reset = 0; run_a = 1;
        tick();
        chk("a_serve_exit", 59'(serving_a), 59'(0));
        chk("b_held_no_run", 59'(serving_b), 59'(1));
        repeat (9) tick();
        chk("a_x_before_step", 59'(ball_x_a), 59'(50));
        tick();
        chk("a_first_step", 59'(ball_x_a), 59'(51));

        run_until(0, 0, 8000, "a_wait_hit0");
        chk("a_hit0_pulse", 59'(hit_a), 59'(2'b01));
        chk("a_hit0_dir", 59'(dir_h_a), 59'(0));
        chk("a_hit0_vel", 59'({vel_h_a, vel_v_a}), 59'({16'd16, 16'd19}));
        chk("a_hit0_x", 59'(ball_x_a), 59'(605));
        tick();
        chk("a_hit0_one_cycle", 59'(hit_a), 59'(0));

        run_until(0, 0, 8000, "a_wait_hit1");
        chk("a_hit1_pulse", 59'(hit_a), 59'(2'b10));
        chk("a_hit1_x", 59'(ball_x_a), 59'(15));
        chk("a_hit1_dir_vel", 59'({dir_h_a, vel_h_a, vel_v_a}), 59'({1'b1, 16'd20, 16'd22}));

        run_a = 0;
        repeat (50) tick();
        chk("a_pause_x", 59'(ball_x_a), 59'(15));
        chk("a_pause_y", 59'(ball_y_a), 59'(10'(ma.y)));

        run_a = 1; px_a = {10'd0, 10'd700};
        run_until(0, 1, 8000, "a_wait_wall");
        chk("a_wall_pulse", 59'({miss_right_a, miss_left_a}), 59'(2'b10));
        chk("a_wall_x", 59'(ball_x_a), 59'(620));
        chk("a_wall_dir", 59'({dir_h_a, serving_a}), 59'(2'b00));
        repeat (20) tick();
        restart_a = 1;
        tick();
        chk("a_restart_pos", 59'({ball_x_a, ball_y_a}), 59'({10'd50, 10'd240}));
        chk("a_restart_vel", 59'({vel_h_a, vel_v_a}), 59'({16'd12, 16'd16}));
        chk("a_restart_flags", 59'({dir_h_a, dir_v_a, serving_a}), 59'(3'b111));
        restart_a = 0;
        tick();
        chk("a_restart_replay", 59'(serving_a), 59'(0));
        run_a = 0;

        // instance B: serve delay, double hit, saturation, re-serve on misses
        run_b = 1;
        repeat (3) tick();
        chk("b_serve_delay_hold", 59'(serving_b), 59'(1));
        tick();
        chk("b_serve_delay_exit", 59'(serving_b), 59'(0));

        run_until(1, 0, 4000, "b_wait_double_hit");
        chk("b_double_hit", 59'(hit_b), 59'(2'b11));
        chk("b_double_dir", 59'(dir_h_b), 59'(0));
        chk("b_double_vel", 59'({vel_h_b, vel_v_b}), 59'({16'd62, 16'd19}));
        chk("b_double_x", 59'(ball_x_b), 59'(605));

        px_b = {10'd285, 10'd625}; side_b = 2'b01;
        run_until(1, 0, 4000, "b_wait_sat_hit");
        chk("b_sat_hit", 59'(hit_b), 59'(2'b10));
        chk("b_sat_x", 59'(ball_x_b), 59'(300));
        chk("b_sat_vel", 59'({dir_h_b, vel_h_b, vel_v_b}), 59'({1'b1, 16'd64, 16'd22}));

        px_b = {10'd285, 10'd700};
        run_until(1, 1, 4000, "b_wait_miss_right");
        chk("b_mr_pulse", 59'({miss_right_b, miss_left_b, serving_b}), 59'(3'b101));
        chk("b_mr_pos", 59'({ball_x_b, ball_y_b}), 59'({10'd50, 10'd240}));
        chk("b_mr_dir_vel", 59'({dir_h_b, vel_h_b, vel_v_b}), 59'({1'b0, 16'd58, 16'd16}));

        run_until(1, 2, 4000, "b_wait_miss_left");
        chk("b_ml_pulse", 59'({miss_right_b, miss_left_b, serving_b}), 59'(3'b011));
        chk("b_ml_dir_x", 59'({dir_h_b, ball_x_b}), 59'({1'b1, 10'd50}));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
